// File: rtl/imem_fetch_unit_if.sv
// Fetch and program-load bus between the IF stage (master) and the instruction memory (slave).
// Latency: none, signal bundle only.
// Backpressure: fetch_req is held by the master until fetch_ready; load_we is never stalled.
interface imem_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WORDS = 512
);
    localparam int LOAD_AW = $clog2(DEPTH_WORDS);

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_flush;
    logic                  fetch_valid;
    logic [WORD_WIDTH-1:0] fetch_instr;
    logic                  fetch_fault;
    logic                  load_we;
    logic [LOAD_AW-1:0]    load_addr;
    logic [WORD_WIDTH-1:0] load_data;
    logic                  busy;

    modport master (
        output fetch_req, fetch_addr, fetch_flush, load_we, load_addr, load_data,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush, load_we, load_addr, load_data,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, busy
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Handshaked word-organised instruction memory with load port; `IMEM_PRELOAD_EN forces the lab program during reset.
// Latency: fetch_valid WAIT_STATES+1 cycles after accept; misaligned/out-of-range fetches fault after 1 cycle.
// Backpressure: fetch_ready low while a fetch waits or load_we is high; fetch_flush drops a waiting fetch.
module imem_fetch_unit #(
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_unit_if.slave fif
);
    localparam int                    AW          = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT  = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]            WAIT_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR   = WORD_WIDTH'(32'hE1A00000);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [AW-1:0]         idx_q;
    logic                  valid_q;
    logic [WORD_WIDTH-1:0] instr_q;
    logic                  fault_q;

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  accept;
    logic                  req_fault;
    logic [AW-1:0]         req_idx;
    logic [WORD_WIDTH-1:0] rd_req;
    logic [WORD_WIDTH-1:0] rd_wait;

`ifdef IMEM_PRELOAD_EN
    localparam int PRELOAD_N = (DEPTH_WORDS < 47) ? DEPTH_WORDS : 47;

    function automatic logic [WORD_WIDTH-1:0] lab_word(input int idx);
        case (idx)
            0:       return WORD_WIDTH'(32'hE3A00014);
            1:       return WORD_WIDTH'(32'hE3A01A01);
            46:      return WORD_WIDTH'(32'hEAFFFFFF);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PRELOAD_N; i++) mem[i] <= lab_word(i);
        end else if (fif.load_we) begin
            mem[fif.load_addr] <= fif.load_data;
        end
    end
`else
    // No reset on the array so it maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (fif.load_we) mem[fif.load_addr] <= fif.load_data;
    end
`endif

    assign fif.fetch_ready = !fif.load_we && (state == S_IDLE || state == S_RESP);
    assign accept          = fif.fetch_req && fif.fetch_ready;
    assign req_idx         = fif.fetch_addr[2 +: AW];
    assign req_fault       = (fif.fetch_addr[1:0] != 2'b00) || ({1'b0, fif.fetch_addr} >= ADDR_LIMIT);

    // A load landing on the word being read this edge wins (write-first).
    always_comb begin
        rd_req = mem[req_idx];
        if (fif.load_we && fif.load_addr == req_idx) rd_req = fif.load_data;
        rd_wait = mem[idx_q];
        if (fif.load_we && fif.load_addr == idx_q) rd_wait = fif.load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    // Flush is ignored here: in RESP the response is already on the bus.
                    if (accept) begin
                        idx_q <= req_idx;
                        if (req_fault) begin
                            state   <= S_RESP;
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                            instr_q <= NOP_INSTR;
                        end else if (WAIT_STATES == 0) begin
                            state   <= S_RESP;
                            valid_q <= 1'b1;
                            fault_q <= 1'b0;
                            instr_q <= rd_req;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_RELOAD;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (fif.fetch_flush) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state   <= S_RESP;
                        valid_q <= 1'b1;
                        fault_q <= 1'b0;
                        instr_q <= rd_wait;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fif.fetch_valid = valid_q;
    assign fif.fetch_instr = instr_q;
    assign fif.fetch_fault = fault_q;
    assign fif.busy        = (state != S_IDLE);
endmodule
